// File: rtl/instr_result_checker.sv
// Instruction-register result checker: scans a range of register entries and checks each
// stored result against the value recomputed from its opcode and operands.
package instr_register_pkg;
    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;
endpackage

module instr_result_checker
    import instr_register_pkg::*;
#(
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [4:0]   first_addr,
    input  logic [4:0]   last_addr,
    output logic [4:0]   read_pointer,
    input  instruction_t instruction_word,
    output logic         busy,
    output logic         done,
    output logic         mismatch,
    output logic [4:0]   mismatch_addr,
    output logic [5:0]   pass_cnt,
    output logic [5:0]   fail_cnt
);

    typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         last_q;
    instruction_t       word_p1;
    logic signed [63:0] expected;
    logic               expected_vld;
    logic               entry_ok;

    function automatic logic [5:0] sat_inc(input logic [5:0] cnt);
        return (cnt >= 6'd32) ? 6'd32 : cnt + 6'd1;
    endfunction

    // Returns {known_opcode, expected}; operands are sign-extended to the result width.
    function automatic logic [64:0] expected_result(input instruction_t w);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = {{32{w.op_a[31]}}, w.op_a};
        b = {{32{w.op_b[31]}}, w.op_b};
        case (w.opc)
            ZERO:    return {1'b1, 64'sd0};
            PASSA:   return {1'b1, a};
            PASSB:   return {1'b1, b};
            ADD:     return {1'b1, a + b};
            SUB:     return {1'b1, a - b};
            MULT:    return {1'b1, a * b};
            DIV:     return {1'b1, (b == 64'sd0) ? 64'sd0 : a / b};
            MOD:     return {1'b1, (b == 64'sd0) ? 64'sd0 : a % b};
            default: return {1'b0, 64'sd0};
        endcase
    endfunction

    always_comb begin
        {expected_vld, expected} = expected_result(word_p1);
        entry_ok = expected_vld && (expected == word_p1.result);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = abort ? IDLE : CHECK;
            CHECK: begin
                if (abort)
                    state_nxt = IDLE;
                else if ((read_pointer == last_q) || (STOP_ON_FAIL && !entry_ok))
                    state_nxt = DONE;
                else
                    state_nxt = READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer  <= 5'd0;
            pass_cnt      <= 6'd0;
            fail_cnt      <= 6'd0;
            mismatch      <= 1'b0;
            mismatch_addr <= 5'd0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        read_pointer <= first_addr;
                        pass_cnt     <= 6'd0;
                        fail_cnt     <= 6'd0;
                    end
                end
                CHECK: begin
                    // An abort here drops the compare result along with the scan.
                    if (!abort) begin
                        if (entry_ok) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            fail_cnt      <= sat_inc(fail_cnt);
                            mismatch      <= 1'b1;
                            mismatch_addr <= read_pointer;
                        end
                        if (state_nxt == READ)
                            read_pointer <= read_pointer + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: scan bound captured at start, register word captured at the end of READ.
    always_ff @(posedge clk) begin
        if (state == IDLE && start)
            last_q <= last_addr;
        if (state == READ)
            word_p1 <= instruction_word;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_instr_result_checker.sv
// Bench for instr_result_checker: directed scenarios plus randomized register contents and scan
// ranges, checked against a per-entry reference model of the expected-result rules.
module tb_instr_result_checker;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [4:0]   first_addr;
    logic [4:0]   last_addr;
    logic         start [2];
    logic         abort [2];
    logic [4:0]   rp [2];
    instruction_t word [2];
    logic         busy [2];
    logic         done [2];
    logic         mm [2];
    logic [4:0]   mma [2];
    logic [5:0]   pc [2];
    logic [5:0]   fc [2];

    instruction_t mem [32];
    logic [4:0]   m_mma [2];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    assign word[0] = mem[rp[0]];
    assign word[1] = mem[rp[1]];

    instr_result_checker #(.STOP_ON_FAIL(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]),
        .first_addr(first_addr), .last_addr(last_addr), .read_pointer(rp[0]),
        .instruction_word(word[0]), .busy(busy[0]), .done(done[0]), .mismatch(mm[0]),
        .mismatch_addr(mma[0]), .pass_cnt(pc[0]), .fail_cnt(fc[0])
    );

    instr_result_checker #(.STOP_ON_FAIL(1'b1)) u_sof (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]),
        .first_addr(first_addr), .last_addr(last_addr), .read_pointer(rp[1]),
        .instruction_word(word[1]), .busy(busy[1]), .done(done[1]), .mismatch(mm[1]),
        .mismatch_addr(mma[1]), .pass_cnt(pc[1]), .fail_cnt(fc[1])
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_value(input instruction_t w, output bit known);
        longint a = w.op_a;
        longint b = w.op_b;
        known = 1'b1;
        case (w.opc)
            ZERO:    return 0;
            PASSA:   return a;
            PASSB:   return b;
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     return (b == 0) ? 0 : a / b;
            MOD:     return (b == 0) ? 0 : a % b;
            default: begin known = 1'b0; return 0; end
        endcase
    endfunction

    function automatic bit entry_pass(input instruction_t w);
        bit known;
        longint v = ref_value(w, known);
        return known && (v == longint'(w.result));
    endfunction

    function automatic instruction_t mk(input opcode_t o, input int a, input int b, input longint r);
        instruction_t w;
        w.opc = o; w.op_a = a; w.op_b = b; w.result = r;
        return w;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            instruction_t w;
            bit known;
            longint v;
            w.opc  = opcode_t'(4'($urandom_range(0, 9)));
            w.op_a = int'($urandom_range(0, 40)) - 20;
            w.op_b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 40)) - 20;
            v = ref_value(w, known);
            if (!known) v = longint'($urandom_range(0, 100));
            else if ($urandom_range(0, 3) == 0) v = v + 1;
            w.result = v;
            mem[i] = w;
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        chk({tag, "_busy"}, busy[d], 0);
        chk({tag, "_done"}, done[d], 0);
        chk({tag, "_mm"}, mm[d], 0);
        chk({tag, "_mma"}, mma[d], 0);
        chk({tag, "_rp"}, rp[d], 0);
        chk({tag, "_pass"}, pc[d], 0);
        chk({tag, "_fail"}, fc[d], 0);
    endtask

    // Full scan on instance d: model the entry list, then watch the DUT cycle by cycle.
    task automatic run_scan(input int d, input logic [4:0] f, input logic [4:0] l, input string tag);
        logic [4:0] diff = l - f;
        logic [4:0] addr = f;
        logic [4:0] addrs[$];
        int n_total = int'(diff) + 1;
        int npass = 0, nfail = 0, done_cyc = -1, done_pulses = 0, mm_pulses = 0;
        for (int i = 0; i < n_total; i++) begin
            addrs.push_back(addr);
            if (entry_pass(mem[addr])) npass++;
            else begin
                nfail++;
                m_mma[d] = addr;
                if (d == 1) break;
            end
            addr = addr + 5'd1;
        end
        first_addr = f; last_addr = l; start[d] = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_start"}, busy[d], 1);
        chk({tag, "_cnt_clear"}, {pc[d], fc[d]}, 0);
        first_addr = 5'($urandom); last_addr = 5'($urandom);
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            if (done[d]) begin done_pulses++; if (done_cyc < 0) done_cyc = cyc; end
            if (mm[d]) mm_pulses++;
            if ((cyc % 2 == 1) && ((cyc - 1) / 2 < addrs.size()))
                chk({tag, "_rp"}, rp[d], addrs[(cyc - 1) / 2]);
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                chk({tag, "_idle_after_done"}, busy[d], 0);
                break;
            end
        end
        start[d] = 1'b0;
        chk({tag, "_done_cycle"}, done_cyc, 2 * addrs.size() + 1);
        chk({tag, "_done_pulses"}, done_pulses, 1);
        chk({tag, "_pass_cnt"}, pc[d], npass);
        chk({tag, "_fail_cnt"}, fc[d], nfail);
        chk({tag, "_mm_pulses"}, mm_pulses, nfail);
        chk({tag, "_mm_addr"}, mma[d], m_mma[d]);
    endtask

    task automatic watch_no_done(input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done[0] || done[1]) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0; abort[0] = 1'b0; abort[1] = 1'b0;
        first_addr = 5'd0; last_addr = 5'd0;
        m_mma[0] = 5'd0; m_mma[1] = 5'd0;
        for (int i = 0; i < 32; i++) mem[i] = mk(ADD, 1, 1, 2);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset_sof");
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) mem[i] = mk(ADD, 5, 3, 8);
        run_scan(0, 5'd0, 5'd3, "add4");
        chk("add4_pass_const", pc[0], 4);

        mem[2] = mk(SUB, 2, 7, 5);
        run_scan(0, 5'd0, 5'd3, "sub_fail");
        chk("sub_fail_addr_const", mma[0], 2);
        chk("sub_fail_cnt_const", {pc[0], fc[0]}, {6'd3, 6'd1});

        mem[30] = mk(ADD, 1, 2, 3); mem[31] = mk(MULT, -3, 4, -12);
        mem[0]  = mk(PASSA, -9, 4, -9); mem[1] = mk(PASSB, 7, -6, -6);
        run_scan(0, 5'd30, 5'd1, "wrap");

        mem[4] = mk(DIV, 9, 0, 0);  mem[5] = mk(MOD, 9, 0, 0);
        mem[6] = mk(DIV, -7, 2, -3); mem[7] = mk(MOD, -7, 2, -1);
        run_scan(0, 5'd4, 5'd7, "divmod");
        chk("divmod_fail_const", fc[0], 0);

        mem[8] = mk(opcode_t'(4'd12), 0, 0, 0);
        run_scan(0, 5'd8, 5'd8, "bad_opcode");
        mem[9] = mk(ZERO, 3, 4, 0);
        run_scan(0, 5'd9, 5'd9, "single");
        run_scan(0, 5'd10, 5'd9, "all32");

        for (int i = 0; i < 6; i++) mem[i] = mk(ADD, i, 1, i + 1);
        mem[1] = mk(ADD, 1, 1, 3);
        run_scan(1, 5'd0, 5'd5, "sof");
        chk("sof_cnt_const", {pc[1], fc[1]}, {6'd1, 6'd1});

        mem[1] = mk(ADD, 1, 1, 2);
        first_addr = 5'd0; last_addr = 5'd5; start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1;
        chk("start_over_abort", busy[0], 1);
        start[0] = 1'b0;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_read_idle", busy[0], 0);
        chk("abort_read_cnt", {pc[0], fc[0]}, 0);

        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_c3_idle", busy[0], 0);
        chk("abort_c3_cnt", {pc[0], fc[0]}, {6'd1, 6'd0});
        chk("abort_c3_rp", rp[0], 1);
        watch_no_done(6, "abort_c3_no_done");

        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_check_cnt", {pc[0], fc[0]}, 0);
        chk("abort_check_rp", rp[0], 0);

        mem[3] = mk(SUB, 0, 1, 0);
        start[0] = 1'b1; start[1] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (8) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_idle_outputs(0, "mid_reset");
        check_idle_outputs(1, "mid_reset_sof");
        m_mma[0] = 5'd0; m_mma[1] = 5'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        watch_no_done(8, "reset_no_done");
        run_scan(0, 5'd0, 5'd5, "after_reset");

        for (int t = 0; t < 12; t++) begin
            fill_random();
            run_scan(int'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_result_checker.md
INSTR_RESULT_CHECKER -- requirements
Module: instr_result_checker

Interface
REQ-001 Parameter STOP_ON_FAIL, default 0: 1 = end the scan at the first mismatching entry.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a scan; sampled only in IDLE.
REQ-005 abort  input  1  terminate the scan in progress.
REQ-006 first_addr  input  5  first register entry to check.
REQ-007 last_addr  input  5  last register entry to check (inclusive).
REQ-008 read_pointer  output  5  read address driven to the instruction register.
REQ-009 instruction_word  input  instruction_t  combinational read data from the register (opc, op_a, op_b, result; instr_register_pkg types).
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse when a scan completes normally.
REQ-012 mismatch  output  1  one-cycle pulse per failing entry.
REQ-013 mismatch_addr  output  5  address of the most recent failing entry.
REQ-014 pass_cnt  output  6  entries passed in the current/last scan.
REQ-015 fail_cnt  output  6  entries failed in the current/last scan.

Function
REQ-016 FSM states SHALL be IDLE, READ, CHECK and DONE.
REQ-017 IDLE: start=1 -> READ; read_pointer<=first_addr; pass_cnt<=0; fail_cnt<=0.
REQ-018 READ: read_pointer held stable; instruction_word registered at the end of the cycle; -> CHECK.
REQ-019 CHECK: expected computed from the registered word and compared with its result field; pass_cnt or fail_cnt +1.
REQ-020 CHECK exit: read_pointer==last_addr, or (STOP_ON_FAIL=1 and entry failed) -> DONE; else read_pointer+1 -> READ.
REQ-021 DONE: done=1 for exactly this cycle; -> IDLE.
REQ-022 Throughput: 2 cycles per entry; done asserted 2N+1 cycles after the start edge for N entries.
REQ-023 Address wrap: 31+1 -> 0; entries checked = ((last_addr-first_addr) mod 32)+1, range 1..32.
REQ-024 first_addr==last_addr -> exactly one entry checked.
REQ-025 first_addr and last_addr SHALL be captured on the accepted start; later changes have no effect until the next scan.
REQ-026 Expected-result rule: operands sign-extended to result width; arithmetic signed, full result width.
REQ-027 Expected per opcode: ZERO=0; PASSA=a; PASSB=b; ADD=a+b; SUB=a-b; MULT=a*b; DIV=a/b (truncate toward zero); MOD=a%b (sign of a).
REQ-028 DIV or MOD with b==0 SHALL expect 0.
REQ-029 An opcode outside the enumerated set SHALL be counted as a fail.
REQ-030 A failing entry SHALL set mismatch=1 and mismatch_addr=read_pointer in the CHECK-exit cycle.
REQ-031 start while busy=1, including in DONE, SHALL be ignored.
REQ-032 abort=1 in READ or CHECK -> IDLE next edge; no done pulse; counts and read_pointer hold; an in-flight CHECK compare is discarded.
REQ-033 abort and start together in IDLE: start wins.
REQ-034 Counts SHALL hold after DONE until the next accepted start; counts saturate at 32.

Reset
REQ-035 reset_n low SHALL immediately force IDLE, read_pointer=0, busy=0, done=0, mismatch=0, mismatch_addr=0, pass_cnt=0, fail_cnt=0.
REQ-036 Reset mid-scan SHALL abandon the scan with no done pulse; the first start after release SHALL be honoured.

Verification
REQ-037 Register preloaded with ADD 5,3,8 at 0..3; start, first=0, last=3 -> pass_cnt=4, fail_cnt=0, done 9 cycles after start.
REQ-038 Entry 2 holds SUB 2,7,result 5 (expected -5) -> mismatch pulse, mismatch_addr=2, fail_cnt=1, pass_cnt=3.
REQ-039 first=30, last=1 -> read_pointer sequence 30,31,0,1; 4 entries counted.
REQ-040 DIV 9,0,0 and MOD 9,0,0 -> both pass; DIV -7,2,-3 passes; MOD -7,2,-1 passes.
REQ-041 STOP_ON_FAIL=1 with failure at entry 1 of 0..5 -> done after entry 1; pass_cnt=1, fail_cnt=1.
REQ-042 abort in cycle 3 of scan, then reset_n pulse mid-second scan -> no done pulse in either case; all outputs 0 after reset.
